// File: rtl/spim_data_buffer_sync_pkg.sv
// Shared helpers for the SPI master data buffer: frame-length decode,
// in-frame bit reversal with masking, and frame-length field width.
package spim_pkg;

  // Widest frame the helpers handle; instantiating with a larger
  // DATA_WIDTH would silently truncate the frame processing.
  localparam int MAX_DW = 128;
  localparam int MAX_AW = $clog2(MAX_DW);

  // Width of the frame-length field for a given data width.
  function automatic int flw_of(input int dw);
    return $clog2(dw);
  endfunction

  // Frame length field holds N-1.
  function automatic int frame_n(input int frame_len);
    return frame_len + 1;
  endfunction

  // Keep bits [n-1:0] (optionally mirrored within the frame), zero the rest.
  function automatic logic [MAX_DW-1:0] frame_proc(input logic [MAX_DW-1:0] d,
                                                   input int n, input logic rev);
    logic [MAX_DW-1:0] r;
    logic [MAX_AW-1:0] idx;
    r = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      idx = MAX_AW'(n - 1 - i);
      if (i < n) r[i] = rev ? d[idx] : d[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/spim_data_buffer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module spim_sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf_pulse,
  output logic                  udf_pulse
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_ok, rd_ok;

  assign level = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                 (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // A read frees a slot in the same cycle, so full+we+re still writes;
  // an empty FIFO never serves a read, even with a same-cycle write.
  assign wr_ok     = we && (!full || re) && !clear;
  assign rd_ok     = re && !empty && !clear;
  assign ovf_pulse = we && full && !re && !clear;
  assign udf_pulse = re && empty && !clear;

  assign rdata = mem[rptr[ADDR_WIDTH-1:0]];

  // Pointer update; flush dominates any same-cycle access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/spim_data_buffer_sync.sv
// TX/RX data buffer between register block and SPI engine. TX words are
// frame-processed on write and stored; RX words are stored raw and
// frame-processed on read with the live configuration.
module spim_data_buffer_sync import spim_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FLW        = flw_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_clear,
  input  logic                  rx_clear,
  input  logic                  tx_we,
  input  logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_re,
  output logic [DATA_WIDTH-1:0] tx_rdata,
  output logic [ADDR_WIDTH:0]   tx_level,
  output logic                  tx_empty,
  output logic                  tx_full,
  input  logic                  rx_we,
  input  logic [DATA_WIDTH-1:0] rx_wdata,
  input  logic                  rx_re,
  output logic [DATA_WIDTH-1:0] rx_rdata,
  output logic [ADDR_WIDTH:0]   rx_level,
  output logic                  rx_empty,
  output logic                  rx_full,
  input  logic [FLW-1:0]        r_frame_len,
  input  logic                  r_tx_msblsb,
  input  logic                  r_rx_msblsb,
  input  logic [ADDR_WIDTH:0]   r_tx_watermark,
  input  logic [ADDR_WIDTH:0]   r_rx_watermark,
  input  logic                  int_clr_tx_ovf,
  input  logic                  int_clr_rx_ovf,
  input  logic                  int_clr_rx_udf,
  output logic                  int_status_tx_fifo_empty,
  output logic                  int_status_tx_fifo_warning,
  output logic                  int_status_rx_fifo_noempty,
  output logic                  int_status_rx_fifo_warning,
  output logic                  int_status_tx_overflow,
  output logic                  int_status_rx_overflow,
  output logic                  int_status_rx_underflow
);

  logic [DATA_WIDTH-1:0] tx_proc, rx_raw;
  logic                  tx_ovf_p, rx_ovf_p, rx_udf_p;
  logic                  tx_udf_unused;
  int                    frame_bits;

  assign frame_bits = frame_n(int'(r_frame_len));

  // TX frame shaping happens once, at write time.
  assign tx_proc = DATA_WIDTH'(frame_proc(MAX_DW'(tx_wdata), frame_bits, r_tx_msblsb));

  // RX frame shaping follows the live config, so reprogramming is visible at once.
  assign rx_rdata = DATA_WIDTH'(frame_proc(MAX_DW'(rx_raw), frame_bits, r_rx_msblsb));

  spim_sync_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (tx_clear),
    .we        (tx_we),
    .re        (tx_re),
    .wdata     (tx_proc),
    .rdata     (tx_rdata),
    .level     (tx_level),
    .empty     (tx_empty),
    .full      (tx_full),
    .ovf_pulse (tx_ovf_p),
    .udf_pulse (tx_udf_unused)  // engine guards TX reads with tx_empty
  );

  spim_sync_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (rx_clear),
    .we        (rx_we),
    .re        (rx_re),
    .wdata     (rx_wdata),
    .rdata     (rx_raw),
    .level     (rx_level),
    .empty     (rx_empty),
    .full      (rx_full),
    .ovf_pulse (rx_ovf_p),
    .udf_pulse (rx_udf_p)
  );

  assign int_status_tx_fifo_empty   = tx_empty;
  assign int_status_tx_fifo_warning = (tx_level <= r_tx_watermark);
  assign int_status_rx_fifo_noempty = ~rx_empty;
  assign int_status_rx_fifo_warning = (rx_level >= r_rx_watermark) && (r_rx_watermark != '0);

  // Sticky error flags; a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_status_tx_overflow  <= 1'b0;
      int_status_rx_overflow  <= 1'b0;
      int_status_rx_underflow <= 1'b0;
    end else begin
      if (tx_ovf_p)            int_status_tx_overflow  <= 1'b1;
      else if (int_clr_tx_ovf) int_status_tx_overflow  <= 1'b0;
      if (rx_ovf_p)            int_status_rx_overflow  <= 1'b1;
      else if (int_clr_rx_ovf) int_status_rx_overflow  <= 1'b0;
      if (rx_udf_p)            int_status_rx_underflow <= 1'b1;
      else if (int_clr_rx_udf) int_status_rx_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spim_data_buffer_sync.sv
// Directed bench for spim_data_buffer_sync with a queue-based reference model
// checked every cycle, plus literal expectations from hand calculation.
module tb_spim_data_buffer_sync;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          tx_clear = 0, rx_clear = 0;
  logic          tx_we = 0, tx_re = 0, rx_we = 0, rx_re = 0;
  logic [DW-1:0] tx_wdata = '0, rx_wdata = '0;
  logic [DW-1:0] tx_rdata, rx_rdata;
  logic [AW:0]   tx_level, rx_level;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [4:0]    r_frame_len = 5'd31;
  logic          r_tx_msblsb = 0, r_rx_msblsb = 0;
  logic [AW:0]   r_tx_watermark = '0, r_rx_watermark = '0;
  logic          int_clr_tx_ovf = 0, int_clr_rx_ovf = 0, int_clr_rx_udf = 0;
  logic          st_tx_empty, st_tx_warn, st_rx_noempty, st_rx_warn;
  logic          st_tx_ovf, st_rx_ovf, st_rx_udf;

  int n_checks = 0;
  int n_errors = 0;

  spim_data_buffer_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .tx_clear(tx_clear), .rx_clear(rx_clear),
    .tx_we(tx_we), .tx_wdata(tx_wdata), .tx_re(tx_re), .tx_rdata(tx_rdata),
    .tx_level(tx_level), .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_we(rx_we), .rx_wdata(rx_wdata), .rx_re(rx_re), .rx_rdata(rx_rdata),
    .rx_level(rx_level), .rx_empty(rx_empty), .rx_full(rx_full),
    .r_frame_len(r_frame_len), .r_tx_msblsb(r_tx_msblsb), .r_rx_msblsb(r_rx_msblsb),
    .r_tx_watermark(r_tx_watermark), .r_rx_watermark(r_rx_watermark),
    .int_clr_tx_ovf(int_clr_tx_ovf), .int_clr_rx_ovf(int_clr_rx_ovf),
    .int_clr_rx_udf(int_clr_rx_udf),
    .int_status_tx_fifo_empty(st_tx_empty), .int_status_tx_fifo_warning(st_tx_warn),
    .int_status_rx_fifo_noempty(st_rx_noempty), .int_status_rx_fifo_warning(st_rx_warn),
    .int_status_tx_overflow(st_tx_ovf), .int_status_rx_overflow(st_rx_ovf),
    .int_status_rx_underflow(st_rx_udf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  bit m_tx_ovf, m_rx_ovf, m_rx_udf;

  // Keep the low N bits, mirror them inside the frame if requested.
  function automatic logic [DW-1:0] frame(input logic [DW-1:0] d, input int len, input bit rev);
    logic [DW-1:0] m;
    int n;
    n = len + 1;
    m = d & DW'((64'd1 << n) - 64'd1);
    if (rev) m = {<<{m}} >> (DW - n);
    return m;
  endfunction

  always @(negedge rstn) begin
    txq.delete();
    rxq.delete();
    m_tx_ovf = 0; m_rx_ovf = 0; m_rx_udf = 0;
  end

  always @(posedge clk) begin : model
    bit pop, push, t_ovf, r_ovf, r_udf;
    if (rstn) begin
      t_ovf = 0; r_ovf = 0; r_udf = 0;
      if (tx_clear) txq.delete();
      else begin
        t_ovf = tx_we && !tx_re && (txq.size() == DEPTH);
        pop   = tx_re && (txq.size() > 0);
        push  = tx_we && ((txq.size() < DEPTH) || tx_re);
        if (pop)  void'(txq.pop_front());
        if (push) txq.push_back(frame(tx_wdata, int'(r_frame_len), r_tx_msblsb));
      end
      if (rx_clear) rxq.delete();
      else begin
        r_ovf = rx_we && !rx_re && (rxq.size() == DEPTH);
        r_udf = rx_re && (rxq.size() == 0);
        pop   = rx_re && (rxq.size() > 0);
        push  = rx_we && ((rxq.size() < DEPTH) || rx_re);
        if (pop)  void'(rxq.pop_front());
        if (push) rxq.push_back(rx_wdata);
      end
      if (t_ovf) m_tx_ovf = 1; else if (int_clr_tx_ovf) m_tx_ovf = 0;
      if (r_ovf) m_rx_ovf = 1; else if (int_clr_rx_ovf) m_rx_ovf = 0;
      if (r_udf) m_rx_udf = 1; else if (int_clr_rx_udf) m_rx_udf = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison; inputs change only at negedge+1, so this sees a settled view.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("tx_level", 32'(tx_level), 32'(txq.size()));
      chk("tx_empty", 32'(tx_empty), 32'(txq.size() == 0));
      chk("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
      chk("rx_level", 32'(rx_level), 32'(rxq.size()));
      chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
      chk("rx_full",  32'(rx_full),  32'(rxq.size() == DEPTH));
      if (txq.size() > 0) chk("tx_rdata", tx_rdata, txq[0]);
      if (rxq.size() > 0)
        chk("rx_rdata", rx_rdata, frame(rxq[0], int'(r_frame_len), r_rx_msblsb));
      chk("st_tx_empty",   32'(st_tx_empty),   32'(txq.size() == 0));
      chk("st_tx_warn",    32'(st_tx_warn),    32'(txq.size() <= int'(r_tx_watermark)));
      chk("st_rx_noempty", 32'(st_rx_noempty), 32'(rxq.size() != 0));
      chk("st_rx_warn",    32'(st_rx_warn),
          32'((rxq.size() >= int'(r_rx_watermark)) && (r_rx_watermark != 0)));
      chk("st_tx_ovf", 32'(st_tx_ovf), 32'(m_tx_ovf));
      chk("st_rx_ovf", 32'(st_rx_ovf), 32'(m_rx_ovf));
      chk("st_rx_udf", 32'(st_rx_udf), 32'(m_rx_udf));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    step(); step();
    chk("rst tx_level", 32'(tx_level), 0);
    chk("rst tx_empty", 32'(tx_empty), 1);
    chk("rst rx_empty", 32'(rx_empty), 1);
    chk("rst tx_full",  32'(tx_full), 0);
    chk("rst flags", 32'({st_tx_ovf, st_rx_ovf, st_rx_udf}), 0);
    rstn = 1'b1;
    step();

    // Fill TX, overflow, drain in order.
    for (int i = 1; i <= 16; i++) begin
      tx_we = 1; tx_wdata = 32'(i); step();
    end
    tx_we = 0;
    chk("fill tx_level", 32'(tx_level), 16);
    chk("fill tx_full",  32'(tx_full), 1);
    tx_we = 1; tx_wdata = 32'h11; step(); tx_we = 0;
    chk("ovf flag", 32'(st_tx_ovf), 1);
    chk("ovf level", 32'(tx_level), 16);
    int_clr_tx_ovf = 1; step(); int_clr_tx_ovf = 0;
    chk("ovf cleared", 32'(st_tx_ovf), 0);
    tx_re = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain tx_rdata", tx_rdata, 32'(i));
      step();
    end
    tx_re = 0;
    chk("drain tx_empty", 32'(tx_empty), 1);

    // TX 8-bit frame, reversed.
    r_frame_len = 5'd7; r_tx_msblsb = 1;
    tx_we = 1; tx_wdata = 32'hFFFF_FF01; step(); tx_we = 0;
    chk("tx rev8", tx_rdata, 32'h0000_0080);
    tx_re = 1; step(); tx_re = 0;
    r_tx_msblsb = 0;

    // RX 16-bit frame, live reversal toggle.
    r_frame_len = 5'd15; r_rx_msblsb = 1;
    rx_we = 1; rx_wdata = 32'h0000_0001; step(); rx_we = 0;
    chk("rx rev16", rx_rdata, 32'h0000_8000);
    r_rx_msblsb = 0; #1;
    chk("rx norev16", rx_rdata, 32'h0000_0001);
    rx_re = 1; step(); rx_re = 0;

    // RX empty with write+read: write lands, underflow flagged.
    rx_we = 1; rx_re = 1; rx_wdata = 32'hFFFF_00AB; step(); rx_we = 0; rx_re = 0;
    chk("udf level", 32'(rx_level), 1);
    chk("udf flag", 32'(st_rx_udf), 1);
    chk("udf rdata masked", rx_rdata, 32'h0000_00AB);
    int_clr_rx_udf = 1; step(); int_clr_rx_udf = 0;
    chk("udf cleared", 32'(st_rx_udf), 0);
    rx_re = 1; step(); rx_re = 0;

    // TX clear dominating a write.
    r_frame_len = 5'd31;
    for (int i = 0; i < 8; i++) begin
      tx_we = 1; tx_wdata = 32'hA000_0000 + 32'(i); step();
    end
    tx_we = 0;
    chk("pre-clear level", 32'(tx_level), 8);
    tx_clear = 1; tx_we = 1; tx_wdata = 32'hDEAD_BEEF; step(); tx_clear = 0; tx_we = 0;
    chk("clear level", 32'(tx_level), 0);
    chk("clear empty", 32'(tx_empty), 1);
    chk("clear no ovf", 32'(st_tx_ovf), 0);
    r_tx_watermark = 5'd2; #1;
    chk("tx warn", 32'(st_tx_warn), 1);

    // RX watermark and full-boundary behaviour.
    r_rx_watermark = 5'd4;
    for (int i = 0; i < 4; i++) begin
      rx_we = 1; rx_wdata = 32'h10 + 32'(i); step();
    end
    rx_we = 0;
    chk("rx wm4 level", 32'(rx_level), 4);
    chk("rx wm4 warn", 32'(st_rx_warn), 1);
    r_rx_watermark = 5'd0; #1;
    chk("rx wm0 warn", 32'(st_rx_warn), 0);
    for (int i = 0; i < 12; i++) begin
      rx_we = 1; rx_wdata = 32'h100 + 32'(i); step();
    end
    chk("rx full", 32'(rx_full), 1);
    rx_re = 1; step(); rx_re = 0;
    chk("full we+re level", 32'(rx_level), 16);
    chk("full we+re no ovf", 32'(st_rx_ovf), 0);
    step(); rx_we = 0;
    chk("rx ovf", 32'(st_rx_ovf), 1);

    // Asynchronous reset in the middle of a TX burst.
    tx_we = 1;
    for (int i = 0; i < 3; i++) begin
      tx_wdata = 32'h5000 + 32'(i); step();
    end
    #2 rstn = 1'b0; #1;
    chk("async tx_level", 32'(tx_level), 0);
    chk("async rx_level", 32'(rx_level), 0);
    chk("async empties", 32'({tx_empty, rx_empty}), 32'h3);
    chk("async flags", 32'({st_tx_ovf, st_rx_ovf, st_rx_udf}), 0);
    tx_we = 0;
    step(); step();
    rstn = 1'b1;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
